// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - funct codes, FSM state encoding and decode helpers for the serial ALU
package alu_pkg;

    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // SLT is a subtract underneath, so it shares B inversion and carry-in of 1.
    function automatic logic is_sub_like(input logic [5:0] f);
        return (f == FUNCT_SUB) || (f == FUNCT_SLT);
    endfunction

    function automatic logic is_supported(input logic [5:0] f);
        return (f == FUNCT_AND) || (f == FUNCT_OR) || (f == FUNCT_ADD) ||
               (f == FUNCT_SUB) || (f == FUNCT_SLT);
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// rtl/alu_bit_slice.sv - combinational 1-bit AND/OR/ADD/SUB slice
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [5:0] funct,
    output logic       out,
    output logic       cout
);

    logic bb;

    always_comb begin
        bb   = b ^ is_sub_like(funct);
        cout = (a & bb) | (a & cin) | (bb & cin);
        case (funct)
            FUNCT_AND: out = a & b;
            FUNCT_OR:  out = a | b;
            FUNCT_ADD,
            FUNCT_SUB,
            FUNCT_SLT: out = a ^ bb ^ cin;
            default:   out = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// rtl/alu_serial_ctrl.sv - bit-serial ALU sequencer, LSB first, one op per WIDTH+2 cycles
// Optional zero flag enabled by defining ALU_SERIAL_ZERO_FLAG_EN.
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             bad_op
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
    logic [5:0]         funct_q, funct_d;
    logic               carry_q, carry_d, bad_op_q, bad_op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               s_out, s_cout, last_bit, slt_lt;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    logic               nz_q, nz_d, zero_q, zero_d;
`endif

    alu_bit_slice u_slice (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .cin   (carry_q),
        .funct (funct_q),
        .out   (s_out),
        .cout  (s_cout)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    // Signed less-than: sign of difference corrected by MSB overflow.
    assign slt_lt   = s_out ^ (carry_q ^ s_cout);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            funct_q  <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            bad_op_q <= 1'b0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
            nz_q     <= 1'b0;
            zero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            funct_q  <= funct_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            bad_op_q <= bad_op_d;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
            nz_q     <= nz_d;
            zero_q   <= zero_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        funct_d  = funct_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        bad_op_d = bad_op_q;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
        nz_d     = nz_q;
        zero_d   = zero_q;
`endif
        if (state_q == IDLE && start) begin
            a_d      = dataA;
            b_d      = dataB;
            funct_d  = funct;
            carry_d  = is_sub_like(funct);
            cnt_d    = '0;
            bad_op_d = !is_supported(funct);
`ifdef ALU_SERIAL_ZERO_FLAG_EN
            nz_d     = 1'b0;
`endif
        end else if (state_q == RUN) begin
            a_d      = a_q >> 1;
            b_d      = b_q >> 1;
            carry_d  = s_cout;
            cnt_d    = cnt_q + CNT_W'(1);
            result_d = {s_out, result_q[WIDTH-1:1]};
`ifdef ALU_SERIAL_ZERO_FLAG_EN
            nz_d     = nz_q | s_out;
`endif
            if (last_bit) begin
                if (bad_op_q)
                    result_d = '0;
                else if (funct_q == FUNCT_SLT)
                    result_d = {{(WIDTH-1){1'b0}}, slt_lt};
`ifdef ALU_SERIAL_ZERO_FLAG_EN
                if (bad_op_q)
                    zero_d = 1'b1;
                else if (funct_q == FUNCT_SLT)
                    zero_d = !slt_lt;
                else
                    zero_d = !(nz_q | s_out);
`endif
            end
        end
    end

    always_comb begin
        busy = (state_q == RUN) || (state_q == DONE);
        done = (state_q == DONE);
    end

    assign result = result_q;
    assign bad_op = bad_op_q;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    assign zero   = zero_q;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb/tb_alu_serial_ctrl.sv - randomized self-checking bench for alu_serial_ctrl
module tb_alu_serial_ctrl;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset, start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] dataA, dataB, result;
    logic             busy, done, bad_op, zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct  (funct),
        .dataA  (dataA),
        .dataB  (dataB),
        .busy   (busy),
        .done   (done),
        .result (result),
        .bad_op (bad_op)
`ifdef ALU_SERIAL_ZERO_FLAG_EN
        ,
        .zero   (zero)
`endif
    );

`ifndef ALU_SERIAL_ZERO_FLAG_EN
    assign zero = 1'b0;
`endif

    function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic bo);
        bo = 1'b0;
        case (f)
            6'b100100: r = a & b;
            6'b100101: r = a | b;
            6'b100000: r = a + b;
            6'b100010: r = a - b;
            6'b101010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: begin r = 32'd0; bo = 1'b1; end
        endcase
    endfunction

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic bo, output logic z,
                          output int lat, output int busy_err);
        r = '0; bo = 1'b0; z = 1'b0; lat = -1; busy_err = 0;
        @(negedge clk);
        start = 1'b1; funct = f; dataA = a; dataB = b;
        @(posedge clk); #1;
        start = 1'b0; funct = 6'($urandom); dataA = $urandom; dataB = $urandom;
        if (busy !== 1'b1) busy_err++;
        for (int k = 1; k <= WIDTH + 8 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (busy !== 1'b1) busy_err++;
            if (done === 1'b1) begin
                lat = k; r = result; bo = bad_op; z = zero;
            end
        end
        @(posedge clk); #1;
        if (busy !== 1'b0 || done !== 1'b0) busy_err++;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; funct = 6'b100000; dataA = 32'd1; dataB = 32'd2;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        total++;
        if ({busy, done, bad_op, zero} !== 4'b0000 || result !== '0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b bad_op=%b zero=%b result=%h, want all 0",
                     busy, done, bad_op, zero, result);
        end
        reset = 1'b0;
    endtask

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a, b, r;
        logic        bo;
    } vec_t;

    task automatic test_directed;
        vec_t v[$];
        logic [31:0] r; logic bo, z; int lat, be;
        v.push_back('{6'b100000, 32'd5,        32'd7,        32'h0000000C, 1'b0});
        v.push_back('{6'b100010, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0});
        v.push_back('{6'b100010, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0});
        v.push_back('{6'b101010, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0});
        v.push_back('{6'b101010, 32'h7FFFFFFF, 32'h80000000, 32'd0,        1'b0});
        v.push_back('{6'b101010, 32'd4,        32'd4,        32'd0,        1'b0});
        v.push_back('{6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0});
        v.push_back('{6'b100101, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0});
        v.push_back('{6'b000000, 32'h12345678, 32'h9ABCDEF0, 32'd0,        1'b1});
        foreach (v[i]) begin
            run_op(v[i].f, v[i].a, v[i].b, r, bo, z, lat, be);
            total++;
            if (lat != WIDTH || be != 0) begin
                bad++;
                $display("FAIL dir%0d_timing: latency=%0d busy_errors=%0d, want latency=%0d busy_errors=0",
                         i, lat, be, WIDTH);
            end
            total++;
            if (r !== v[i].r || bo !== v[i].bo) begin
                bad++;
                $display("FAIL dir%0d_result: funct=%b result=%h bad_op=%b, want %h bad_op=%b",
                         i, v[i].f, r, bo, v[i].r, v[i].bo);
            end
        end
    endtask

    task automatic test_random;
        logic [5:0] ops[6] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010, 6'b011111};
        logic [31:0] a, b, r, er; logic bo, ebo, z; int lat, be;
        for (int i = 0; i < 24; i++) begin
            a = $urandom; b = $urandom;
            if (i % 6 == 5) b = a;
            if (i % 8 == 7) a = 32'h80000000;
            model(ops[$urandom_range(0, 5)], a, b, er, ebo);
            funct = ops[$urandom_range(0, 5)];
            model(funct, a, b, er, ebo);
            run_op(funct, a, b, r, bo, z, lat, be);
            total++;
            if (r !== er || bo !== ebo || lat != WIDTH || be != 0) begin
                bad++;
                $display("FAIL rand%0d: a=%h b=%h result=%h bad_op=%b lat=%0d busy_err=%0d, want %h bad_op=%b lat=%0d",
                         i, a, b, r, bo, lat, be, er, ebo, WIDTH);
            end
`ifdef ALU_SERIAL_ZERO_FLAG_EN
            total++;
            if (z !== (er == 32'd0)) begin
                bad++;
                $display("FAIL rand%0d_zero: zero=%b, want %b", i, z, (er == 32'd0));
            end
`endif
        end
    endtask

    task automatic test_ignore_start;
        int ndone = 0;
        logic [31:0] r = '0;
        @(negedge clk);
        start = 1'b1; funct = 6'b100000; dataA = 32'd5; dataB = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start = (k == 5 || k == 33);
            dataA = 32'd100; dataB = 32'd200;
            @(posedge clk); #1;
            if (done === 1'b1) begin ndone++; r = result; end
        end
        start = 1'b0;
        total++;
        if (ndone != 1 || r !== 32'h0000000C || busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_start: dones=%0d result=%h busy=%b, want 1 dones result=0000000c busy=0",
                     ndone, r, busy);
        end
    endtask

    task automatic test_mid_reset;
        int ndone = 0;
        logic [31:0] r; logic bo, z; int lat, be;
        @(negedge clk);
        start = 1'b1; funct = 6'b000000; dataA = 32'hFFFFFFFF; dataB = 32'h1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || bad_op !== 1'b0 || zero !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_state: busy=%b done=%b result=%h bad_op=%b zero=%b, want all 0",
                     busy, done, result, bad_op, zero);
        end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        total++;
        if (ndone != 0) begin
            bad++;
            $display("FAIL mid_reset_no_done: dones=%0d, want 0", ndone);
        end
        run_op(6'b100000, 32'd5, 32'd7, r, bo, z, lat, be);
        total++;
        if (r !== 32'h0000000C || bo !== 1'b0 || lat != WIDTH || be != 0) begin
            bad++;
            $display("FAIL after_reset_op: result=%h bad_op=%b lat=%0d busy_err=%0d, want 0000000c 0 %0d 0",
                     r, bo, lat, be, WIDTH);
        end
    endtask

`ifdef ALU_SERIAL_ZERO_FLAG_EN
    task automatic test_zero;
        logic [31:0] r; logic bo, z; int lat, be;
        run_op(6'b100010, 32'd9, 32'd9, r, bo, z, lat, be);
        total++;
        if (z !== 1'b1 || r !== 32'd0) begin
            bad++;
            $display("FAIL zero_sub: zero=%b result=%h, want zero=1 result=0", z, r);
        end
        run_op(6'b100000, 32'd1, 32'd1, r, bo, z, lat, be);
        total++;
        if (z !== 1'b0 || r !== 32'd2) begin
            bad++;
            $display("FAIL zero_add: zero=%b result=%h, want zero=0 result=2", z, r);
        end
        total++;
        if (zero !== 1'b0) begin
            bad++;
            $display("FAIL zero_held: zero=%b, want 0", zero);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; funct = '0; dataA = '0; dataB = '0;
        test_reset;
        test_directed;
        test_random;
        test_ignore_start;
        test_mid_reset;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
        test_zero;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
